mult_mac_ctrl: RTL and testbench
================================

MULT_MAC_CTRL -- requirements
Module: mult_mac_ctrl

Interface
REQ-001 SHALL have parameter ACC_W, 24, accumulator/result width in bits (min 16).
REQ-002 SHALL have parameter TIMEOUT, 32, max cycles to wait for mul_done per launch.
REQ-003 SHALL have port clock  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-high reset (asserted = 1).
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  operand FIFO can accept.
REQ-007 SHALL have port in_a  input  8  operand A, signed.
REQ-008 SHALL have port in_b  input  8  operand B.
REQ-009 SHALL have port in_last  input  1  pair closes current accumulation group.
REQ-010 SHALL have port mul_start  output  1  start to downstream multiplier.
REQ-011 SHALL have port mul_a  output  8  DataA to multiplier.
REQ-012 SHALL have port mul_b  output  8  DataB to multiplier.
REQ-013 SHALL have port mul_done  input  1  multiplier done.
REQ-014 SHALL have port mul_product  input  16  multiplier product, signed.
REQ-015 SHALL have port acc_valid  output  1  group result available.
REQ-016 SHALL have port acc_ready  input  1  consumer accepts result.
REQ-017 SHALL have port acc_out  output  ACC_W  group sum.
REQ-018 SHALL have port acc_count  output  8  pairs in group.
REQ-019 SHALL have port err  output  1  sticky timeout flag.
REQ-020 SHALL have port busy  output  1  FSM not IDLE or FIFO non-empty.

Function
REQ-021 SHALL buffer pairs {in_a,in_b,in_last} in 4-entry FIFO; push when in_valid && in_ready.
REQ-022 SHALL drive in_ready = 0 when FIFO holds 4 entries, even if a pop occurs same cycle.
REQ-023 SHALL, when FIFO empty, never pop and never launch.
REQ-024 SHALL implement FSM IDLE, LAUNCH, WAIT, RELEASE, EMIT.
REQ-025 IDLE: FIFO non-empty -> pop head into operand registers, go LAUNCH next cycle.
REQ-026 LAUNCH: mul_start = 1, mul_a/mul_b from operand registers; go WAIT next cycle.
REQ-027 WAIT: hold mul_start = 1 and operands stable; on mul_done = 1 capture mul_product, go RELEASE.
REQ-028 WAIT: if mul_done not seen within TIMEOUT cycles of entering LAUNCH, set err, discard pair (no accumulate, no count), go RELEASE.
REQ-029 RELEASE: mul_start = 0; add sign-extended captured product to accumulator (mod 2^ACC_W, no saturation), increment acc_count (wraps at 255); if pair had in_last go EMIT, else IDLE; stay in RELEASE while mul_done = 1.
REQ-030 EMIT: acc_valid = 1, acc_out/acc_count stable until acc_ready = 1; on accept clear accumulator and count, go IDLE.
REQ-031 SHALL keep mul_start = 0 in IDLE, RELEASE, EMIT; no new launch before mul_done seen low.
REQ-032 SHALL, for a timed-out last pair, still enter EMIT with sum of accepted pairs.
REQ-033 SHALL continue accepting FIFO pushes in every state, including EMIT.
REQ-034 Latency: pair at FIFO head to accumulated = multiplier latency + 3 cycles.
REQ-035 err SHALL clear only on reset.

Reset
REQ-036 On reset_n = 1 at clock edge: FSM -> IDLE, FIFO emptied, accumulator and acc_count = 0, err = 0.
REQ-037 Reset outputs: in_ready = 1 after release, mul_start = 0, mul_a = mul_b = 0, acc_valid = 0, acc_out = 0, busy = 0.
REQ-038 Reset mid-operation SHALL abandon any launch in progress, dropping mul_start the following cycle.

Verification
REQ-039 Single pair (3,5,last) -> mul_start rises, after done acc_valid = 1, acc_out = 15, acc_count = 1.
REQ-040 Group (2,3),(4,5),(0xFF,1,last) -> acc_out = 25 (2+20-1... 6+20-1), acc_count = 3, one acc_valid pulse.
REQ-041 Five pushes with multiplier stalled -> in_ready = 0 after 4th, 5th held off until pop.
REQ-042 mul_done tied 0 for one pair (7,7,last) -> err = 1 after TIMEOUT cycles, acc_out = 0, acc_count = 0 emitted.
REQ-043 acc_ready = 0 for 10 cycles in EMIT -> acc_out/acc_count stable, FIFO still fills, no launch.
REQ-044 reset_n = 1 during WAIT -> next cycle mul_start = 0, busy = 0, acc_out = 0, err = 0.

Source files
------------

// File: rtl/mult_mac_ctrl.sv
// ---------------------------------------------------------------------------
// mult_mac_ctrl
// Multiply-accumulate sequencer. Operand pairs are queued in a 4-entry FIFO.
// Each pair is sent to an external multiplier with a start/done handshake.
// The signed products are summed into an accumulator. When a pair tagged
// "last" completes, the group sum and pair count are offered on a
// valid/ready output.
//
// Ports
//   clock, reset_n       : clock; synchronous reset, active HIGH despite name
//   in_valid/in_ready    : operand push handshake
//   in_a, in_b, in_last  : operands (A signed) and end-of-group marker
//   mul_start            : held high from launch until mul_done or timeout
//   mul_a, mul_b         : operands presented to the multiplier
//   mul_done             : multiplier result strobe
//   mul_product          : signed 16-bit multiplier result
//   acc_valid/acc_ready  : group result handshake
//   acc_out, acc_count   : group sum (mod 2^ACC_W) and accepted pair count
//   err                  : sticky multiplier timeout flag, cleared by reset
//   busy                 : FSM not idle or FIFO holding pairs
// ---------------------------------------------------------------------------
module mult_mac_ctrl #(
   parameter int ACC_W   = 24,
   parameter int TIMEOUT = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   input  logic             in_last,
   output logic             mul_start,
   output logic [7:0]       mul_a,
   output logic [7:0]       mul_b,
   input  logic             mul_done,
   input  logic [15:0]      mul_product,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [7:0]       acc_count,
   output logic             err,
   output logic             busy
);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_RELEASE,
      S_EMIT
   } state_t;

   state_t           state_q, state_d;
   logic [16:0]      fifo_mem_q [4];
   logic [16:0]      fifo_mem_d [4];
   logic [1:0]       wr_ptr_q, wr_ptr_d;
   logic [1:0]       rd_ptr_q, rd_ptr_d;
   logic [2:0]       fifo_cnt_q, fifo_cnt_d;
   logic [7:0]       op_a_q, op_a_d;
   logic [7:0]       op_b_q, op_b_d;
   logic             op_last_q, op_last_d;
   logic [15:0]      prod_q, prod_d;
   logic             prod_ok_q, prod_ok_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             mul_start_q, mul_start_d;
   logic             acc_valid_q, acc_valid_d;
   logic             push, pop;

   // in_ready depends only on the stored count, so a full FIFO refuses a push
   // even in a cycle where the FSM pops the head.
   assign in_ready  = (fifo_cnt_q != 3'd4);
   assign push      = in_valid && in_ready;
   assign pop       = (state_q == S_IDLE) && (fifo_cnt_q != 3'd0);

   assign mul_start = mul_start_q;
   assign mul_a     = op_a_q;
   assign mul_b     = op_b_q;
   assign acc_valid = acc_valid_q;
   assign acc_out   = acc_q;
   assign acc_count = cnt_q;
   assign err       = err_q;
   assign busy      = (state_q != S_IDLE) || (fifo_cnt_q != 3'd0);

   // Circular-buffer bookkeeping. Each entry packs {last, a, b}. Pushes are
   // accepted in every FSM state, and pops only happen from IDLE.
   always_comb begin
      fifo_mem_d = fifo_mem_q;
      if (push) begin
         fifo_mem_d[wr_ptr_q] = {in_last, in_a, in_b};
      end
      wr_ptr_d   = wr_ptr_q + 2'(push);
      rd_ptr_d   = rd_ptr_q + 2'(pop);
      fifo_cnt_d = fifo_cnt_q + 3'(push) - 3'(pop);
   end

   // Sequencer next-state logic. timer counts cycles since LAUNCH, with
   // LAUNCH itself as cycle 0, so mul_start is held for at most TIMEOUT
   // cycles. The product is folded into the accumulator on the cycle that
   // RELEASE is left. RELEASE is held while mul_done stays high, so a single
   // result is added only once. A timed-out pair is dropped from the sum and
   // from the count. If that pair was the last of its group, EMIT still runs.
   always_comb begin
      state_d   = state_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      op_last_d = op_last_q;
      prod_d    = prod_q;
      prod_ok_d = prod_ok_q;
      timer_d   = timer_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               op_last_d = fifo_mem_q[rd_ptr_q][16];
               op_a_d    = fifo_mem_q[rd_ptr_q][15:8];
               op_b_d    = fifo_mem_q[rd_ptr_q][7:0];
               timer_d   = '0;
               state_d   = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            timer_d = timer_q + 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mul_done) begin
               prod_d    = mul_product;
               prod_ok_d = 1'b1;
               state_d   = S_RELEASE;
            end else if (timer_q >= T_LIM) begin
               err_d     = 1'b1;
               prod_ok_d = 1'b0;
               state_d   = S_RELEASE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_RELEASE: begin
            if (!mul_done) begin
               if (prod_ok_q) begin
                  acc_d = acc_q + ACC_W'($signed(prod_q));
                  cnt_d = cnt_q + 8'd1;
               end
               state_d = op_last_q ? S_EMIT : S_IDLE;
            end
         end
         S_EMIT: begin
            if (acc_ready) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      mul_start_d = (state_d == S_LAUNCH) || (state_d == S_WAIT);
      acc_valid_d = (state_d == S_EMIT);
   end

   // All state, including the registered handshake outputs, with synchronous
   // reset. A reset during a launch drops mul_start on the next edge.
   always_ff @(posedge clock) begin
      if (reset_n) begin
         state_q     <= S_IDLE;
         fifo_mem_q  <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_last_q   <= 1'b0;
         prod_q      <= '0;
         prod_ok_q   <= 1'b0;
         timer_q     <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         mul_start_q <= 1'b0;
         acc_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fifo_mem_q  <= fifo_mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_last_q   <= op_last_d;
         prod_q      <= prod_d;
         prod_ok_q   <= prod_ok_d;
         timer_q     <= timer_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         mul_start_q <= mul_start_d;
         acc_valid_q <= acc_valid_d;
      end
   end

endmodule

// File: tb/tb_mult_mac_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_mac_ctrl
// Self-checking bench for mult_mac_ctrl. The bench includes a behavioural
// multiplier with random or fixed latency. A reference model keeps every
// accepted pair in order. On each accepted result it sums the signed
// products of the group, skipping pairs expected to time out. It reduces the
// sum mod 2^ACC_W and the pair count mod 256.
// ---------------------------------------------------------------------------
module tb_mult_mac_ctrl;

   localparam int ACC_W   = 24;
   localparam int TIMEOUT = 32;
   localparam longint ACC_MASK = (longint'(1) << ACC_W) - 1;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       last;
      logic       drop;
   } pair_t;

   logic             clock, reset_n;
   logic             in_valid, in_ready, in_last;
   logic [7:0]       in_a, in_b;
   logic             mul_start, mul_done;
   logic [7:0]       mul_a, mul_b;
   logic [15:0]      mul_product;
   logic             acc_valid, acc_ready;
   logic [ACC_W-1:0] acc_out;
   logic [7:0]       acc_count;
   logic             err, busy;

   int    checks = 0;
   int    errors = 0;
   int    launches = 0;
   int    emits = 0;
   logic  prev_start = 1'b0;
   int    ready_mode = 0;
   bit    push_rand = 1'b0;
   logic  mul_en = 1'b1;
   int    lat_fixed = -1;
   logic [31:0] last_out = '0;
   logic [31:0] last_cnt = '0;
   pair_t pend[$];
   pair_t exp_pairs[$];

   logic        m_active;
   int          m_wcnt, m_hold;
   logic [15:0] m_prod;

   mult_mac_ctrl #(.ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_done(mul_done), .mul_product(mul_product),
      .acc_valid(acc_valid), .acc_ready(acc_ready),
      .acc_out(acc_out), .acc_count(acc_count),
      .err(err), .busy(busy)
   );

   // Free-running 10-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case the stimulus process ever stalls.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Multiplier model. On every falling edge it samples mul_start. It
   // returns signed(a)*signed(b) after a latency of 0-3 cycles, or after
   // lat_fixed cycles when that is set. It then holds done for 1-3 cycles.
   // With mul_en low it never answers.
   initial begin
      int pa, pb;
      mul_done    = 1'b0;
      mul_product = '0;
      m_active    = 1'b0;
      m_wcnt      = 0;
      m_hold      = 0;
      m_prod      = '0;
      forever begin
         @(negedge clock);
         if (!mul_en) begin
            m_active = 1'b0;
            m_hold   = 0;
            mul_done = 1'b0;
         end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) mul_done = 1'b0;
         end else if (m_active) begin
            if (m_wcnt == 0) begin
               mul_done    = 1'b1;
               mul_product = m_prod;
               m_active    = 1'b0;
               m_hold      = $urandom_range(1, 3);
            end else begin
               m_wcnt--;
            end
         end else if (mul_start) begin
            pa       = $signed(mul_a);
            pb       = $signed(mul_b);
            m_prod   = 16'(pa * pb);
            m_active = 1'b1;
            m_wcnt   = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
         end
      end
   end

   function automatic pair_t mkPair(input logic [7:0] a, input logic [7:0] b,
                                    input logic last, input logic drop);
      pair_t p;
      p.a = a; p.b = b; p.last = last; p.drop = drop;
      return p;
   endfunction

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model for one accepted result. It consumes pairs up to and
   // including the next "last" pair, then checks the group sum and count.
   task automatic checkEmit();
      longint sum = 0;
      int     n = 0;
      bit     found = 1'b0;
      int     pa, pb;
      pair_t  p;
      while (!found && exp_pairs.size() > 0) begin
         p = exp_pairs.pop_front();
         if (!p.drop) begin
            pa = $signed(p.a);
            pb = $signed(p.b);
            sum += longint'(pa * pb);
            n++;
         end
         found = p.last;
      end
      checkOutput("emit_has_group", 32'(found), 32'd1);
      checkOutput("acc_out", 32'(acc_out), 32'(sum & ACC_MASK));
      checkOutput("acc_count", 32'(acc_count), 32'(n % 256));
      last_out = 32'(acc_out);
      last_cnt = 32'(acc_count);
   endtask

   // One cycle of stimulus, applied at the falling edge. It picks acc_ready.
   // It checks a result that will be accepted on the next rising edge, and it
   // offers the next pending pair, which is recorded if in_ready is high.
   task automatic applyStimulus();
      @(negedge clock);
      if (mul_start && !prev_start) launches++;
      prev_start = mul_start;
      case (ready_mode)
         0:       acc_ready = 1'b1;
         1:       acc_ready = ($urandom_range(0, 2) != 0);
         default: acc_ready = 1'b0;
      endcase
      if (acc_valid && acc_ready) begin
         emits++;
         checkEmit();
      end
      if (pend.size() > 0 && (!push_rand || ($urandom_range(0, 1) == 1))) begin
         in_valid = 1'b1;
         in_a     = pend[0].a;
         in_b     = pend[0].b;
         in_last  = pend[0].last;
         if (in_ready) exp_pairs.push_back(pend.pop_front());
      end else begin
         in_valid = 1'b0;
      end
   endtask

   // Run until all pending pairs are pushed and the design is idle, within a
   // cycle budget.
   task automatic waitIdle(input int budget, input string tag);
      int n = 0;
      while ((pend.size() > 0 || in_valid || busy || acc_valid) && n < budget) begin
         applyStimulus();
         n++;
      end
      checkOutput({tag, "_drained"}, 32'(n < budget), 32'd1);
      checkOutput({tag, "_groups_left"}, 32'(exp_pairs.size()), 32'd0);
   endtask

   initial begin
      int n, l0, e0;
      reset_n   = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_last   = 1'b0;
      acc_ready = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);

      // Reset state
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_mul_start", 32'(mul_start), 32'd0);
      checkOutput("rst_mul_a", 32'(mul_a), 32'd0);
      checkOutput("rst_mul_b", 32'(mul_b), 32'd0);
      checkOutput("rst_acc_valid", 32'(acc_valid), 32'd0);
      checkOutput("rst_acc_out", 32'(acc_out), 32'd0);
      checkOutput("rst_acc_count", 32'(acc_count), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);

      // Single pair 3*5
      l0 = launches; e0 = emits;
      pend.push_back(mkPair(8'd3, 8'd5, 1'b1, 1'b0));
      waitIdle(300, "single");
      checkOutput("single_launches", 32'(launches - l0), 32'd1);
      checkOutput("single_emits", 32'(emits - e0), 32'd1);
      checkOutput("single_out", last_out, 32'd15);
      checkOutput("single_cnt", last_cnt, 32'd1);

      // Three-pair group including a negative operand: 6 + 20 - 1
      e0 = emits;
      pend.push_back(mkPair(8'd2, 8'd3, 1'b0, 1'b0));
      pend.push_back(mkPair(8'd4, 8'd5, 1'b0, 1'b0));
      pend.push_back(mkPair(8'hFF, 8'd1, 1'b1, 1'b0));
      waitIdle(300, "group3");
      checkOutput("group3_emits", 32'(emits - e0), 32'd1);
      checkOutput("group3_out", last_out, 32'd25);
      checkOutput("group3_cnt", last_cnt, 32'd3);

      // FIFO full while the multiplier is slow: 1 in flight + 4 queued
      lat_fixed = 20;
      pend.push_back(mkPair(8'd1, 8'd1, 1'b0, 1'b0));
      pend.push_back(mkPair(8'd2, 8'd2, 1'b0, 1'b0));
      pend.push_back(mkPair(8'd3, 8'd3, 1'b1, 1'b0));
      pend.push_back(mkPair(8'd4, 8'd4, 1'b0, 1'b0));
      pend.push_back(mkPair(8'd5, 8'd5, 1'b0, 1'b0));
      pend.push_back(mkPair(8'd6, 8'd6, 1'b1, 1'b0));
      repeat (12) applyStimulus();
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      checkOutput("full_held_pairs", 32'(pend.size()), 32'd1);
      checkOutput("full_busy", 32'(busy), 32'd1);
      lat_fixed = -1;
      waitIdle(600, "full");

      // Multiplier never answers: the pair times out and an empty group is emitted
      mul_en = 1'b0;
      pend.push_back(mkPair(8'd7, 8'd7, 1'b1, 1'b1));
      n = 0;
      while (!mul_start && n < 20) begin applyStimulus(); n++; end
      checkOutput("to_launch_seen", 32'(mul_start), 32'd1);
      repeat (TIMEOUT - 2) applyStimulus();
      checkOutput("to_err_early", 32'(err), 32'd0);
      checkOutput("to_start_held", 32'(mul_start), 32'd1);
      n = 0;
      while (!err && n < 6) begin applyStimulus(); n++; end
      checkOutput("to_err_set", 32'(err), 32'd1);
      waitIdle(100, "timeout");
      checkOutput("to_out", last_out, 32'd0);
      checkOutput("to_cnt", last_cnt, 32'd0);
      mul_en = 1'b1;

      // Consumer stalls in EMIT: outputs hold, FIFO fills, nothing launches
      ready_mode = 2;
      pend.push_back(mkPair(8'd1, 8'd2, 1'b1, 1'b0));
      n = 0;
      while (!acc_valid && n < 200) begin applyStimulus(); n++; end
      checkOutput("hold_reached_emit", 32'(acc_valid), 32'd1);
      pend.push_back(mkPair(8'd1, 8'd1, 1'b0, 1'b0));
      pend.push_back(mkPair(8'd2, 8'd2, 1'b0, 1'b0));
      pend.push_back(mkPair(8'd3, 8'd3, 1'b0, 1'b0));
      pend.push_back(mkPair(8'd4, 8'd4, 1'b1, 1'b0));
      for (int i = 0; i < 10; i++) begin
         applyStimulus();
         checkOutput("hold_valid", 32'(acc_valid), 32'd1);
         checkOutput("hold_out", 32'(acc_out), 32'd2);
         checkOutput("hold_cnt", 32'(acc_count), 32'd1);
         checkOutput("hold_no_launch", 32'(mul_start), 32'd0);
      end
      checkOutput("hold_fifo_full", 32'(in_ready), 32'd0);
      checkOutput("hold_all_pushed", 32'(pend.size()), 32'd0);
      ready_mode = 0;
      waitIdle(300, "hold");
      checkOutput("hold_second_out", last_out, 32'd30);

      // Extreme operands, then randomised traffic
      ready_mode = 1;
      push_rand  = 1'b1;
      pend.push_back(mkPair(8'h80, 8'h80, 1'b0, 1'b0));
      pend.push_back(mkPair(8'h80, 8'h7F, 1'b0, 1'b0));
      pend.push_back(mkPair(8'hFF, 8'hFF, 1'b1, 1'b0));
      for (int i = 0; i < 150; i++) begin
         pend.push_back(mkPair(8'($urandom), 8'($urandom),
                               ($urandom_range(0, 3) == 0) || (i == 149), 1'b0));
      end
      waitIdle(8000, "random");
      checkOutput("err_sticky", 32'(err), 32'd1);

      // Long group: accumulator wraps mod 2^ACC_W and count wraps mod 256
      ready_mode = 0;
      push_rand  = 1'b0;
      lat_fixed  = 0;
      for (int i = 0; i < 1030; i++) begin
         pend.push_back(mkPair(8'h80, 8'h80, i == 1029, 1'b0));
      end
      waitIdle(20000, "wrap");
      checkOutput("wrap_out", last_out, 32'd98304);
      checkOutput("wrap_cnt", last_cnt, 32'd6);

      // Reset while the multiplier is being waited on
      lat_fixed = 20;
      pend.push_back(mkPair(8'd3, 8'd3, 1'b1, 1'b0));
      n = 0;
      while (!mul_start && n < 50) begin applyStimulus(); n++; end
      checkOutput("rst_wait_launch", 32'(mul_start), 32'd1);
      repeat (3) applyStimulus();
      @(negedge clock);
      reset_n   = 1'b1;
      mul_en    = 1'b0;
      in_valid  = 1'b0;
      acc_ready = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      checkOutput("rst_mid_mul_start", 32'(mul_start), 32'd0);
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_acc_out", 32'(acc_out), 32'd0);
      checkOutput("rst_mid_err", 32'(err), 32'd0);
      checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
      exp_pairs.delete();
      pend.delete();
      prev_start = mul_start;
      repeat (2) applyStimulus();
      mul_en    = 1'b1;
      lat_fixed = -1;
      pend.push_back(mkPair(8'd3, 8'd5, 1'b1, 1'b0));
      waitIdle(300, "recover");
      checkOutput("recover_out", last_out, 32'd15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
